// File: rtl/gray_code_counter.sv
// Gray-code sequence source: binary count with up/down, load and wrap flag,
// presented through a single registered valid/ready slot.
module gray_code_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] g_out,
    output logic             g_valid,
    input  logic             g_ready,
    output logic             wrap,
    output logic [WIDTH-1:0] count_bin
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;
    logic             adv;
    logic             at_term;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // The slot may be refilled when empty or when its code leaves this edge.
    assign adv       = !g_valid || g_ready;
    assign at_term   = up_dn ? (count == CNT_MAX) : (count == '0);
    assign count_bin = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            g_out   <= '0;
            g_valid <= 1'b0;
            wrap    <= 1'b0;
        end else if (adv) begin
            if (load) begin
                // Count takes the loaded value so the next en re-emits it.
                g_out   <= to_gray(load_val);
                g_valid <= 1'b1;
                count   <= load_val;
                wrap    <= 1'b0;
            end else if (en) begin
                g_out   <= to_gray(count);
                g_valid <= 1'b1;
                count   <= up_dn ? count + CNT_ONE : count - CNT_ONE;
                wrap    <= at_term;
            end else begin
                g_valid <= 1'b0;
                wrap    <= 1'b0;
            end
        end
    end

endmodule
